// File: rtl/cmult_tw_pkg.sv
// cmult_tw_pkg: shared definitions for the twiddle complex multiplier.
// Holds the rounding-mode enum, the default parameter constants and the
// accumulator-width helper used by the interface, the top and the rounder.
// No ports (package).
package cmult_tw_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_TW_W   = 10;
  localparam int DEF_OUT_W  = 15;
  localparam int DEF_SHIFT  = 10;

  typedef enum logic {
    RND_FLOOR = 1'b0,
    RND_SYM   = 1'b1
  } rnd_mode_t;

  // One extra bit over a single product so the sum/difference of two
  // products never wraps.
  function automatic int acc_width(input int data_w, input int tw_w);
    return data_w + tw_w + 32'sd1;
  endfunction

endpackage

// File: rtl/cmult_tw_pipe_if.sv
// cmult_tw_pipe_if: sample/twiddle input handshake and result output handshake.
//   in_valid/in_ready      input handshake
//   x_r, x_i               signed sample, DATA_W bits each
//   w_r, w_i               signed twiddle, TW_W bits each
//   conj                   conjugate the twiddle for this sample
//   rnd_mode               0 = floor, 1 = symmetric bias
//   rnd_bias               ACC_W-bit rounding bias, travels with the sample
//   out_valid/out_ready    output handshake
//   out_r, out_i           signed result, OUT_W bits each
// Modports: master (producer/consumer side), slave (the multiplier).
interface cmult_tw_pipe_if
  import cmult_tw_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TW_W   = DEF_TW_W,
  parameter int OUT_W  = DEF_OUT_W
) ();

  localparam int ACC_W = acc_width(DATA_W, TW_W);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x_r;
  logic signed [DATA_W-1:0] x_i;
  logic signed [TW_W-1:0]   w_r;
  logic signed [TW_W-1:0]   w_i;
  logic                     conj;
  logic                     rnd_mode;
  logic signed [ACC_W-1:0]  rnd_bias;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_r;
  logic signed [OUT_W-1:0]  out_i;

  modport master (
    output in_valid, x_r, x_i, w_r, w_i, conj, rnd_mode, rnd_bias, out_ready,
    input  in_ready, out_valid, out_r, out_i
  );

  modport slave (
    input  in_valid, x_r, x_i, w_r, w_i, conj, rnd_mode, rnd_bias, out_ready,
    output in_ready, out_valid, out_r, out_i
  );

endinterface

// File: rtl/cmult_tw_pipe_round_sat.sv
// tw_round_sat: rounding plus output formatting for one component.
//   y         in  ACC_W  full-precision product sum
//   rnd_mode  in  1      RND_FLOOR: pass y; RND_SYM: add bias away from zero
//   rnd_bias  in  ACC_W  rounding bias
//   res       out OUT_W  formatted result (combinational)
// Macro CMULT_TW_SAT_EN: saturate (rounded >>> SHIFT) to the OUT_W range.
// Without it the sign bit is kept and the bits above the output field are
// simply dropped.
module tw_round_sat
  import cmult_tw_pkg::*;
#(
  parameter int ACC_W = acc_width(DEF_DATA_W, DEF_TW_W),
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic signed [ACC_W-1:0] y,
  input  rnd_mode_t               rnd_mode,
  input  logic signed [ACC_W-1:0] rnd_bias,
  output logic signed [OUT_W-1:0] res
);

  logic signed [ACC_W-1:0] rounded_s;

  // Symmetric rounding: sign taken from y's MSB, bias moves away from zero.
  always_comb begin
    rounded_s = y;
    if (rnd_mode == RND_SYM) begin
      if (y[ACC_W-1] == 1'b0) begin
        rounded_s = y + rnd_bias;
      end else begin
        rounded_s = y - rnd_bias;
      end
    end else begin
      rounded_s = y;
    end
  end

`ifdef CMULT_TW_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted_s;

  assign shifted_s = rounded_s >>> SHIFT;

  // Clamp the shifted value into the signed OUT_W range.
  always_comb begin
    res = shifted_s[OUT_W-1:0];
    if (shifted_s > SAT_MAX) begin
      res = SAT_MAX[OUT_W-1:0];
    end else if (shifted_s < SAT_MIN) begin
      res = SAT_MIN[OUT_W-1:0];
    end else begin
      res = shifted_s[OUT_W-1:0];
    end
  end
`else
  // The discarded LSBs and dropped intermediate MSBs are intentionally unused.
  logic unused_bits_s;

  assign unused_bits_s = ^rounded_s;
  assign res = {rounded_s[ACC_W-1], rounded_s[SHIFT+OUT_W-2:SHIFT]};
`endif

endmodule

// File: rtl/cmult_tw_pipe.sv
// cmult_tw_pipe: 3-stage pipelined complex multiply x * w' with rounding.
//   clk     in  rising-edge clock
//   rst_n   in  asynchronous active-low reset (clears valids and outputs)
//   bus     cmult_tw_pipe_if.slave (handshakes, sample, twiddle, controls, result)
// Stages: S1 registers the four partial products, S2 forms the real and
// imaginary sums, S3 registers the rounded/formatted result. The whole pipe
// advances only when the output register is empty or being drained, so
// in_ready is that same global enable. conj, rnd_mode and rnd_bias travel
// with their sample.
// Macro CMULT_TW_SAT_EN: saturating output formatting (see tw_round_sat).
module cmult_tw_pipe
  import cmult_tw_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TW_W   = DEF_TW_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SHIFT  = DEF_SHIFT
) (
  input logic            clk,
  input logic            rst_n,
  cmult_tw_pipe_if.slave bus
);

  localparam int ACC_W = DATA_W + TW_W + 1;

  logic en_s;

  // Operands sign-extended to ACC_W so every product is exact in ACC_W bits.
  logic signed [TW_W:0]    wi_ext_s;
  logic signed [TW_W:0]    wi_c_s;
  logic signed [ACC_W-1:0] xr_e_s, xi_e_s, wr_e_s, wi_e_s;
  logic signed [ACC_W-1:0] p_rr_s, p_ii_s, p_ri_s, p_ir_s;

  logic                    v1_r;
  logic signed [ACC_W-1:0] p_rr_r, p_ii_r, p_ri_r, p_ir_r;
  rnd_mode_t               mode1_r;
  logic signed [ACC_W-1:0] bias1_r;

  logic                    v2_r;
  logic signed [ACC_W-1:0] yr_r, yi_r;
  rnd_mode_t               mode2_r;
  logic signed [ACC_W-1:0] bias2_r;

  logic                    out_valid_r;
  logic signed [OUT_W-1:0] out_r_r, out_i_r;
  logic signed [OUT_W-1:0] fmt_r_s, fmt_i_s;

  assign en_s         = !out_valid_r || bus.out_ready;
  assign bus.in_ready = en_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_r     = out_r_r;
  assign bus.out_i     = out_i_r;

  // Conjugate negation done one bit wider so -(-2^(TW_W-1)) is representable.
  always_comb begin
    wi_ext_s = {bus.w_i[TW_W-1], bus.w_i};
    if (bus.conj) begin
      wi_c_s = (TW_W+1)'(1'b0) - wi_ext_s;
    end else begin
      wi_c_s = wi_ext_s;
    end
  end

  assign xr_e_s = {{(ACC_W-DATA_W){bus.x_r[DATA_W-1]}}, bus.x_r};
  assign xi_e_s = {{(ACC_W-DATA_W){bus.x_i[DATA_W-1]}}, bus.x_i};
  assign wr_e_s = {{(ACC_W-TW_W){bus.w_r[TW_W-1]}}, bus.w_r};
  assign wi_e_s = {{(ACC_W-TW_W-1){wi_c_s[TW_W]}}, wi_c_s};

  assign p_rr_s = xr_e_s * wr_e_s;
  assign p_ii_s = xi_e_s * wi_e_s;
  assign p_ri_s = xr_e_s * wi_e_s;
  assign p_ir_s = xi_e_s * wr_e_s;

  // S1: capture partial products and the per-sample rounding controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      p_rr_r  <= '0;
      p_ii_r  <= '0;
      p_ri_r  <= '0;
      p_ir_r  <= '0;
      mode1_r <= RND_FLOOR;
      bias1_r <= '0;
    end else if (en_s) begin
      v1_r    <= bus.in_valid;
      p_rr_r  <= p_rr_s;
      p_ii_r  <= p_ii_s;
      p_ri_r  <= p_ri_s;
      p_ir_r  <= p_ir_s;
      mode1_r <= rnd_mode_t'(bus.rnd_mode);
      bias1_r <= bus.rnd_bias;
    end
  end

  // S2: complex sum/difference of the partial products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r    <= 1'b0;
      yr_r    <= '0;
      yi_r    <= '0;
      mode2_r <= RND_FLOOR;
      bias2_r <= '0;
    end else if (en_s) begin
      v2_r    <= v1_r;
      yr_r    <= p_rr_r - p_ii_r;
      yi_r    <= p_ri_r + p_ir_r;
      mode2_r <= mode1_r;
      bias2_r <= bias1_r;
    end
  end

  tw_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_r (
    .y        (yr_r),
    .rnd_mode (mode2_r),
    .rnd_bias (bias2_r),
    .res      (fmt_r_s)
  );

  tw_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_i (
    .y        (yi_r),
    .rnd_mode (mode2_r),
    .rnd_bias (bias2_r),
    .res      (fmt_i_s)
  );

  // S3: output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_r_r     <= '0;
      out_i_r     <= '0;
    end else if (en_s) begin
      out_valid_r <= v2_r;
      out_r_r     <= fmt_r_s;
      out_i_r     <= fmt_i_s;
    end
  end

endmodule

// File: tb/tb_cmult_tw_pipe.sv
// tb_cmult_tw_pipe: self-checking bench for cmult_tw_pipe (default parameters).
// Expected results are pushed to a scoreboard queue on input acceptance and
// popped when an output is transferred. Define CMULT_TW_SAT_EN for both the
// RTL and the bench to exercise the saturating build.
`timescale 1ns/1ps
module tb_cmult_tw_pipe;
  import cmult_tw_pkg::*;

  localparam int DATA_W = 16;
  localparam int TW_W   = 10;
  localparam int OUT_W  = 15;
  localparam int SHIFT  = 10;
  localparam int ACC_W  = DATA_W + TW_W + 1;

  typedef struct packed {
    logic signed [OUT_W-1:0] r;
    logic signed [OUT_W-1:0] i;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  cmult_tw_pipe_if #(.DATA_W(DATA_W), .TW_W(TW_W), .OUT_W(OUT_W)) bus ();

  cmult_tw_pipe #(
    .DATA_W (DATA_W),
    .TW_W   (TW_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input int xr, input int xi, input int wr, input int wi,
                       input logic cj, input logic md, input int bias);
    bus.in_valid = v;
    bus.x_r      = DATA_W'(xr);
    bus.x_i      = DATA_W'(xi);
    bus.w_r      = TW_W'(wr);
    bus.w_i      = TW_W'(wi);
    bus.conj     = cj;
    bus.rnd_mode = md;
    bus.rnd_bias = ACC_W'(bias);
  endtask

  function automatic longint fmt(input longint y);
    longint sh;
    longint lo;
    sh = y >>> SHIFT;
`ifdef CMULT_TW_SAT_EN
    if (sh > 16383) return 16383;
    if (sh < -16384) return -16384;
    return sh;
`else
    lo = sh & 16383;
    if (y < 0) return lo - 16384;
    return lo;
`endif
  endfunction

  function automatic exp_t model(input int xr, input int xi, input int wr, input int wi,
                                 input logic cj, input logic md, input int bias);
    longint wic, yr, yi;
    exp_t   e;
    wic = cj ? -longint'(wi) : longint'(wi);
    yr  = longint'(xr) * wr - longint'(xi) * wic;
    yi  = longint'(xr) * wic + longint'(xi) * wr;
    if (md) begin
      yr = (yr >= 0) ? yr + bias : yr - bias;
      yi = (yi >= 0) ? yi + bias : yi - bias;
    end
    e.r = OUT_W'(fmt(yr));
    e.i = OUT_W'(fmt(yi));
    return e;
  endfunction

  // Called at a negedge with inputs already driven: samples the handshake
  // #1 later and returns at the next negedge (after the posedge transfer).
  task automatic tick(output logic acc, output logic ov, output logic ir,
                      output logic fired, output exp_t got);
    #1;
    ir    = bus.in_ready;
    ov    = bus.out_valid;
    acc   = bus.in_valid && bus.in_ready;
    fired = bus.out_valid && bus.out_ready;
    got.r = bus.out_r;
    got.i = bus.out_i;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_tests++;
    if (bus.out_r !== 15'sd0) begin n_fail++; $display("FAIL reset_out_r got %0d want 0", bus.out_r); end
    n_tests++;
    if (bus.out_i !== 15'sd0) begin n_fail++; $display("FAIL reset_out_i got %0d want 0", bus.out_i); end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    logic acc, ov, ir, fired;
    exp_t got, exp;
    int   lat;
    lat = -1;
    drive(1'b1, 16384, 0, 511, 0, 1'b0, 1'b1, 0);
    tick(acc, ov, ir, fired, got);
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      tick(acc, ov, ir, fired, got);
      if (ov) begin
        lat = c;
        exp.r = 15'sd8176;
        exp.i = 15'sd0;
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL latency_value got (%0d,%0d) want (%0d,%0d)", got.r, got.i, exp.r, exp.i); end
      end
    end
    n_tests++;
    if (lat != 3) begin n_fail++; $display("FAIL latency got %0d want 3", lat); end
  endtask

  task automatic test_directed();
    int   xr_t[7], xi_t[7], wr_t[7], wi_t[7], b_t[7], er_t[7], ei_t[7];
    logic cj_t[7], md_t[7];
    logic acc, ov, ir, fired;
    exp_t got, exp;
    int   sent, rcv;
    xr_t = '{16384, 2, -2, 1, 0, 0, 32767};
    xi_t = '{0, 0, 0, 0, 1024, 1024, 32767};
    wr_t = '{511, 256, 256, 511, 0, 0, 511};
    wi_t = '{0, 0, 0, 0, 256, 256, -512};
    cj_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    md_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    b_t  = '{0, 512, 512, 512, 0, 0, 0};
`ifdef CMULT_TW_SAT_EN
    er_t = '{8176, 1, -1, 0, -256, 256, 16383};
`else
    er_t = '{8176, 1, -1, 0, -256, 256, 16351};
`endif
    ei_t = '{0, 0, 0, 0, 0, 0, -32};
    sent = 0;
    rcv  = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && rcv < 7; c++) begin
      if (sent < 7) drive(1'b1, xr_t[sent], xi_t[sent], wr_t[sent], wi_t[sent], cj_t[sent], md_t[sent], b_t[sent]);
      else drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
      tick(acc, ov, ir, fired, got);
      if (acc) begin
        exp.r = OUT_W'(er_t[sent]);
        exp.i = OUT_W'(ei_t[sent]);
        sb_q.push_back(exp);
        sent++;
      end
      if (fired) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL directed_extra got (%0d,%0d) want none", got.r, got.i);
        end else begin
          exp = sb_q.pop_front();
          if (got !== exp) begin n_fail++; $display("FAIL directed_%0d got (%0d,%0d) want (%0d,%0d)", rcv, got.r, got.i, exp.r, exp.i); end
        end
        rcv++;
      end
    end
    n_tests++;
    if (rcv != 7) begin n_fail++; $display("FAIL directed_count got %0d want 7", rcv); end
  endtask

  task automatic test_back_to_back();
    int   xr_t[8], xi_t[8], wr_t[8], wi_t[8], b_t[8];
    logic cj_t[8], md_t[8];
    logic acc, ov, ir, fired;
    exp_t got, exp, held;
    int   sent, rcv;
    for (int k = 0; k < 8; k++) begin
      xr_t[k] = $urandom_range(65535) - 32768;
      xi_t[k] = $urandom_range(65535) - 32768;
      wr_t[k] = $urandom_range(1023) - 512;
      wi_t[k] = $urandom_range(1023) - 512;
      cj_t[k] = 1'($urandom_range(1));
      md_t[k] = 1'($urandom_range(1));
      b_t[k]  = $urandom_range(1023);
    end
    sb_q.delete();
    sent = 0;
    rcv  = 0;
    held = '0;
    for (int c = 0; c < 60 && rcv < 8; c++) begin
      if (sent < 8) drive(1'b1, xr_t[sent], xi_t[sent], wr_t[sent], wi_t[sent], cj_t[sent], md_t[sent], b_t[sent]);
      else drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
      bus.out_ready = (c >= 5 && c < 9) ? 1'b0 : 1'b1;
      tick(acc, ov, ir, fired, got);
      if (c >= 5 && c < 9) begin
        n_tests++;
        if (ir !== 1'b0 || ov !== 1'b1) begin n_fail++; $display("FAIL stall_ready c=%0d got in_ready=%b out_valid=%b want 0/1", c, ir, ov); end
        if (c == 5) held = got;
        else begin
          n_tests++;
          if (got !== held) begin n_fail++; $display("FAIL stall_hold c=%0d got (%0d,%0d) want (%0d,%0d)", c, got.r, got.i, held.r, held.i); end
        end
      end
      if (acc) begin
        sb_q.push_back(model(xr_t[sent], xi_t[sent], wr_t[sent], wi_t[sent], cj_t[sent], md_t[sent], b_t[sent]));
        sent++;
      end
      if (fired) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra got (%0d,%0d) want none", got.r, got.i);
        end else begin
          exp = sb_q.pop_front();
          if (got !== exp) begin n_fail++; $display("FAIL b2b_%0d got (%0d,%0d) want (%0d,%0d)", rcv, got.r, got.i, exp.r, exp.i); end
        end
        rcv++;
      end
    end
    n_tests++;
    if (rcv != 8 || sb_q.size() != 0) begin n_fail++; $display("FAIL b2b_count got %0d left %0d want 8 left 0", rcv, sb_q.size()); end
  endtask

  task automatic test_reset_flight();
    logic acc, ov, ir, fired;
    exp_t got, exp;
    int   seen, rcv;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1000 + k, -500, 300, -200, 1'b0, 1'b1, 100);
      tick(acc, ov, ir, fired, got);
    end
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_r !== 15'sd0 || bus.out_i !== 15'sd0) begin
      n_fail++; $display("FAIL flight_reset got valid=%b (%0d,%0d) want 0 (0,0)", bus.out_valid, bus.out_r, bus.out_i);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick(acc, ov, ir, fired, got);
      if (ov) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL flight_ghost got %0d outputs want 0", seen); end
    sb_q.delete();
    rcv = 0;
    drive(1'b1, -1234, 4321, -77, 401, 1'b1, 1'b1, 300);
    for (int c = 0; c < 10 && rcv < 1; c++) begin
      tick(acc, ov, ir, fired, got);
      if (acc) sb_q.push_back(model(-1234, 4321, -77, 401, 1'b1, 1'b1, 300));
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
      if (fired) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL post_reset_extra got (%0d,%0d) want none", got.r, got.i);
        end else begin
          exp = sb_q.pop_front();
          if (got !== exp) begin n_fail++; $display("FAIL post_reset got (%0d,%0d) want (%0d,%0d)", got.r, got.i, exp.r, exp.i); end
        end
        rcv++;
      end
    end
    n_tests++;
    if (rcv != 1) begin n_fail++; $display("FAIL post_reset_count got %0d want 1", rcv); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_reset_flight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
